sequencer_lut_loader: RTL and testbench
=======================================

Name: sequencer_lut_loader

Overview:
Upstream configuration stage for the sequencer FSM. On command, it copies N sequence-table entries from the register-bank shadow memory into the sequencer LUT write port. It then raises config_done, which gates the sequencer FSM. It will not rewrite the LUT while the sequencer is busy.

Parameters:
LUT_DEPTH, 256, number of LUT entries (addresses 0..LUT_DEPTH-1)
ADDR_W, 8, LUT/source address width, equal to clog2(LUT_DEPTH)
DATA_W, 32, LUT entry width

Ports:
clk_20mhz  input  1  system clock, 20 MHz
rst_n_20mhz  input  1  asynchronous active-low reset
start_i  input  1  single-cycle load request
entry_count_i  input  ADDR_W+1  entries to load, sampled when start_i is accepted
seq_busy_i  input  1  sequencer FSM busy flag
src_rd_o  output  1  shadow memory read strobe
src_addr_o  output  ADDR_W  shadow memory read address
src_data_i  input  DATA_W  shadow read data, valid exactly 1 cycle after src_rd_o
lut_addr_o  output  ADDR_W  LUT address, used for both write and read
lut_wen_o  output  1  LUT write enable
lut_write_data_o  output  DATA_W  LUT write data
lut_read_data_i  input  DATA_W  LUT read data, 1-cycle latency from lut_addr_o (used only by the verify feature)
config_done_o  output  1  LUT holds a complete, valid table
busy_o  output  1  load in progress or pending
load_err_o  output  1  sticky error for bad entry_count; cleared by the next accepted start
verify_err_o  output  1  sticky readback mismatch; cleared by the next accepted start
entries_loaded_o  output  ADDR_W+1  entries written in the current or last load

Behaviour:
- Reset (asynchronous, active-low): state IDLE; every output 0; internal index and count registers 0.
- States: IDLE, PEND, RD, WR, VRD, VCMP, DONE.
- IDLE, start_i=1:
  - Clear config_done_o, load_err_o and verify_err_o.
  - Latch entry_count_i into cnt.
  - If cnt==0 or cnt>LUT_DEPTH: set load_err_o and return to IDLE. No writes occur; config_done_o stays 0.
  - Otherwise go to PEND.
- PEND: busy_o=1. Wait while seq_busy_i=1. When seq_busy_i=0, set idx=0 and go to RD.
- RD: src_rd_o=1, src_addr_o=idx. Next state WR.
- WR:
  - lut_wen_o=1, lut_addr_o=idx, lut_write_data_o=src_data_i; entries_loaded_o increments.
  - If idx==cnt-1, go to VRD (verify compiled in, with idx reset to 0) or DONE.
  - Otherwise idx++ and go to RD.
- Throughput: 2 cycles per entry. A load of N entries reaches DONE 2N+1 cycles after PEND exits.
- DONE: set config_done_o=1 and go to IDLE. config_done_o holds until the next accepted start or reset.
- busy_o: 1 in PEND, RD, WR, VRD, VCMP; 0 in IDLE and DONE.
- start_i while busy_o=1: ignored, with no latch and no error.
- seq_busy_i rising after PEND exits: ignored. The load completes; PEND is the only gate.
- Same-cycle start_i and seq_busy_i=1 in IDLE: enter PEND (rule above).
- idx never exceeds LUT_DEPTH-1; there is no wrap-around.
- Reset mid-load: LUT contents are undefined and config_done_o=0 until a fresh load completes.
- lut_wen_o is never high outside WR; src_rd_o is high only in RD and VRD.

Optional Feature:
Macro: SEQ_LUT_VERIFY_EN.
- Defined:
  - After the last write, read back each entry in order.
  - VRD: lut_addr_o=idx, src_rd_o=1, src_addr_o=idx.
  - VCMP: compare lut_read_data_i with src_data_i. On mismatch, set verify_err_o.
  - Continue through all cnt entries. Verify adds 2N cycles.
  - DONE: config_done_o = ~verify_err_o.
- Not defined: VRD and VCMP do not exist; WR goes directly to DONE; verify_err_o is tied 0.

Decomposition:
- Package seq_lut_pkg:
  - state enum ld_state_t {IDLE, PEND, RD, WR, VRD, VCMP, DONE}
  - LUT_DEPTH default
  - DATA_W default
  - ADDR_W default
- Single module; no sub-module is warranted. The source and LUT memories are external.

Test Plan:
1. start_i with entry_count_i=4 and seq_busy_i=0; shadow holds 0xA000_0000+i -> exactly 4 lut_wen_o pulses at addresses 0..3 with matching data, 2 cycles apart; config_done_o=1 on cycle 10 after start; entries_loaded_o=4.
2. start_i with entry_count_i=0, then a second start_i with entry_count_i=257 -> load_err_o=1 both times; no lut_wen_o; config_done_o stays 0.
3. start_i while seq_busy_i=1 for 50 cycles -> busy_o=1; no src_rd_o or lut_wen_o until seq_busy_i falls; then a normal load.
4. Second start_i during a 16-entry load -> ignored; 16 writes only; config_done_o drops at the first accepted start and rises once.
5. Assert rst_n_20mhz low mid-load (after 3 writes) -> all outputs 0 asynchronously; a new start_i with count 8 completes 8 writes.
6. SEQ_LUT_VERIFY_EN defined; LUT model corrupts address 2 -> verify_err_o=1, config_done_o=0; without corruption config_done_o=1 at 4N+1 cycles.

Source files
------------

// File: rtl/seq_lut_pkg.sv
// Shared types and default sizes for the sequencer LUT loader.
package seq_lut_pkg;

   localparam int DEF_LUT_DEPTH = 256;
   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_DATA_W    = 32;

   typedef enum logic [2:0] {
      IDLE,
      PEND,
      RD,
      WR,
      VRD,
      VCMP,
      DONE
   } ld_state_t;

endpackage

// File: rtl/sequencer_lut_loader.sv
// Sequencer LUT loader: copies entry_count sequence-table entries from the
// register-bank shadow memory into the sequencer LUT, then raises config_done.
// The copy is held off in PEND until the sequencer is idle.
// Optional readback verification is compiled in with SEQ_LUT_VERIFY_EN.
module sequencer_lut_loader
   import seq_lut_pkg::*;
#(
   parameter int LUT_DEPTH = DEF_LUT_DEPTH,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W
)
(
   input  logic              clk_20mhz,
   input  logic              rst_n_20mhz,
   input  logic              start_i,
   input  logic [ADDR_W:0]   entry_count_i,
   input  logic              seq_busy_i,
   output logic              src_rd_o,
   output logic [ADDR_W-1:0] src_addr_o,
   input  logic [DATA_W-1:0] src_data_i,
   output logic [ADDR_W-1:0] lut_addr_o,
   output logic              lut_wen_o,
   output logic [DATA_W-1:0] lut_write_data_o,
   input  logic [DATA_W-1:0] lut_read_data_i,
   output logic              config_done_o,
   output logic              busy_o,
   output logic              load_err_o,
   output logic              verify_err_o,
   output logic [ADDR_W:0]   entries_loaded_o
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(LUT_DEPTH);
   localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

   ld_state_t         state;
   ld_state_t         state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_m1;
   logic [ADDR_W:0]   entries_loaded;
   logic              config_done_q;
   logic              load_err_q;
   logic              count_bad;
   logic              last_entry;
   logic              done_now;
   logic              verify_err_q;

   assign count_bad  = (entry_count_i == '0) || (entry_count_i > DEPTH_CNT);
   assign cnt_m1     = cnt - ONE_CNT;
   assign last_entry = ({1'b0, idx} == cnt_m1);

`ifdef SEQ_LUT_VERIFY_EN
   assign done_now = ~verify_err_q;
`else
   assign done_now = 1'b1;
   assign verify_err_q = 1'b0;
   logic unused_read_data;
   assign unused_read_data = ^lut_read_data_i;
`endif

   assign config_done_o    = config_done_q | ((state == DONE) & done_now);
   assign load_err_o       = load_err_q;
   assign verify_err_o     = verify_err_q;
   assign entries_loaded_o = entries_loaded;

   // State register; reset drops straight back to IDLE mid-load
   always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
      if (!rst_n_20mhz) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and strobe decode; all strobes and addresses are 0 unless the state uses them
   always_comb begin
      state_nxt        = state;
      busy_o           = 1'b0;
      src_rd_o         = 1'b0;
      src_addr_o       = '0;
      lut_addr_o       = '0;
      lut_wen_o        = 1'b0;
      lut_write_data_o = '0;
      case (state)
         IDLE: begin
            if (start_i && !count_bad) begin
               state_nxt = PEND;
            end
         end
         PEND: begin
            busy_o = 1'b1;
            if (!seq_busy_i) begin
               state_nxt = RD;
            end
         end
         RD: begin
            busy_o     = 1'b1;
            src_rd_o   = 1'b1;
            src_addr_o = idx;
            state_nxt  = WR;
         end
         WR: begin
            busy_o           = 1'b1;
            lut_wen_o        = 1'b1;
            lut_addr_o       = idx;
            lut_write_data_o = src_data_i;
            if (last_entry) begin
`ifdef SEQ_LUT_VERIFY_EN
               state_nxt = VRD;
`else
               state_nxt = DONE;
`endif
            end else begin
               state_nxt = RD;
            end
         end
`ifdef SEQ_LUT_VERIFY_EN
         VRD: begin
            busy_o     = 1'b1;
            lut_addr_o = idx;
            src_rd_o   = 1'b1;
            src_addr_o = idx;
            state_nxt  = VCMP;
         end
         VCMP: begin
            busy_o    = 1'b1;
            state_nxt = last_entry ? DONE : VRD;
         end
`endif
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Index, count and status flags; a start is only honoured from IDLE
   always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
      if (!rst_n_20mhz) begin
         idx            <= '0;
         cnt            <= '0;
         entries_loaded <= '0;
         config_done_q  <= 1'b0;
         load_err_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  cnt            <= entry_count_i;
                  entries_loaded <= '0;
                  config_done_q  <= 1'b0;
                  load_err_q     <= count_bad;
               end
            end
            PEND: begin
               if (!seq_busy_i) begin
                  idx <= '0;
               end
            end
            WR: begin
               entries_loaded <= entries_loaded + ONE_CNT;
               if (last_entry) begin
                  idx <= '0;
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
            end
`ifdef SEQ_LUT_VERIFY_EN
            VCMP: begin
               if (!last_entry) begin
                  idx <= idx + ADDR_W'(1);
               end
            end
`endif
            DONE: begin
               config_done_q <= done_now;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SEQ_LUT_VERIFY_EN
   // Sticky readback mismatch flag, cleared by the next accepted start
   always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
      if (!rst_n_20mhz) begin
         verify_err_q <= 1'b0;
      end else if (state == IDLE && start_i) begin
         verify_err_q <= 1'b0;
      end else if (state == VCMP && lut_read_data_i != src_data_i) begin
         verify_err_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sequencer_lut_loader.sv
// Testbench for sequencer_lut_loader: shadow and LUT memory models, a write
// scoreboard filled when a load is requested and drained by the LUT write
// monitor, and directed checks of status outputs and timing.
// Define SEQ_LUT_VERIFY_EN to also exercise the readback verification.
module tb_sequencer_lut_loader;
   import seq_lut_pkg::*;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 32;
   localparam int LUT_DEPTH = 256;

`ifdef SEQ_LUT_VERIFY_EN
   localparam int VERIFY = 1;
`else
   localparam int VERIFY = 0;
`endif

   logic              clk_20mhz = 1'b0;
   logic              rst_n_20mhz = 1'b0;
   logic              start_i = 1'b0;
   logic [ADDR_W:0]   entry_count_i = '0;
   logic              seq_busy_i = 1'b0;
   logic              src_rd_o;
   logic [ADDR_W-1:0] src_addr_o;
   logic [DATA_W-1:0] src_data_i = '0;
   logic [ADDR_W-1:0] lut_addr_o;
   logic              lut_wen_o;
   logic [DATA_W-1:0] lut_write_data_o;
   logic [DATA_W-1:0] lut_read_data_i = '0;
   logic              config_done_o;
   logic              busy_o;
   logic              load_err_o;
   logic              verify_err_o;
   logic [ADDR_W:0]   entries_loaded_o;

   sequencer_lut_loader dut (
      .clk_20mhz        (clk_20mhz),
      .rst_n_20mhz      (rst_n_20mhz),
      .start_i          (start_i),
      .entry_count_i    (entry_count_i),
      .seq_busy_i       (seq_busy_i),
      .src_rd_o         (src_rd_o),
      .src_addr_o       (src_addr_o),
      .src_data_i       (src_data_i),
      .lut_addr_o       (lut_addr_o),
      .lut_wen_o        (lut_wen_o),
      .lut_write_data_o (lut_write_data_o),
      .lut_read_data_i  (lut_read_data_i),
      .config_done_o    (config_done_o),
      .busy_o           (busy_o),
      .load_err_o       (load_err_o),
      .verify_err_o     (verify_err_o),
      .entries_loaded_o (entries_loaded_o)
   );

   // 20 MHz clock
   always #25 clk_20mhz = ~clk_20mhz;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      bit                first;
   } exp_wr_t;

   exp_wr_t           expQ[$];
   exp_wr_t           monE;
   logic [DATA_W-1:0] shadow [LUT_DEPTH];
   logic [DATA_W-1:0] lut    [LUT_DEPTH];
   bit                corruptAddr2 = 1'b0;
   int                vectors = 0;
   int                miscompares = 0;
   int                wrCount = 0;
   int                srcRdCount = 0;
   int                doneRises = 0;
   int                cycleNo = 0;
   int                lastWrCycle = 0;
   logic              prevDone = 1'b0;

   // Free-running cycle counter used for write spacing
   always @(posedge clk_20mhz) cycleNo++;

   // Shadow memory: read data valid one cycle after the strobe
   always @(posedge clk_20mhz) begin
      if (src_rd_o) src_data_i <= shadow[src_addr_o];
   end

   // LUT memory: synchronous write, one-cycle read, optional corruption of address 2 on readback
   always @(posedge clk_20mhz) begin
      if (lut_wen_o) lut[lut_addr_o] <= lut_write_data_o;
      lut_read_data_i <= lut[lut_addr_o] ^ ((corruptAddr2 && lut_addr_o == 8'd2) ? 32'h1 : 32'h0);
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Write monitor: pops the scoreboard on every LUT write and tracks strobe counts
   always @(negedge clk_20mhz) begin
      if (rst_n_20mhz) begin
         if (src_rd_o) srcRdCount++;
         if (config_done_o && !prevDone) doneRises++;
         prevDone = config_done_o;
         if (lut_wen_o) begin
            wrCount++;
            checkOutput("sb_pending", expQ.size() > 0, 1);
            if (expQ.size() > 0) begin
               monE = expQ.pop_front();
               checkOutput("wr_addr", lut_addr_o, monE.addr);
               checkOutput("wr_data", lut_write_data_o, monE.data);
               if (!monE.first) checkOutput("wr_spacing", cycleNo - lastWrCycle, 2);
               lastWrCycle = cycleNo;
            end
         end
      end else begin
         prevDone = 1'b0;
      end
   end

   // Pulse start for one cycle; for a load expected to be accepted, queue its writes
   task automatic applyStimulus(input int count, input bit expectLoad);
      @(negedge clk_20mhz);
      start_i       = 1'b1;
      entry_count_i = count[ADDR_W:0];
      if (expectLoad) begin
         wrCount    = 0;
         srcRdCount = 0;
         for (int i = 0; i < count; i++) begin
            expQ.push_back('{addr: i[ADDR_W-1:0], data: shadow[i], first: (i == 0)});
         end
      end
      @(negedge clk_20mhz);
      start_i = 1'b0;
   endtask

   // Wait (bounded) for busy to fall; returns the cycle index counted from the start cycle
   task automatic waitIdle(input int budget, output int cycles);
      cycles = 1;
      while (busy_o && cycles < budget) begin
         @(negedge clk_20mhz);
         cycles++;
      end
      checkOutput("wait_idle", busy_o, 0);
   endtask

   // Hard stop if something hangs outside the bounded waits
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int c;
      int doneBefore;
      for (int i = 0; i < LUT_DEPTH; i++) shadow[i] = 32'hA000_0000 + i;

      // Reset state
      repeat (2) @(negedge clk_20mhz);
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_src_rd", src_rd_o, 0);
      checkOutput("rst_wen", lut_wen_o, 0);
      checkOutput("rst_done", config_done_o, 0);
      checkOutput("rst_load_err", load_err_o, 0);
      checkOutput("rst_verify_err", verify_err_o, 0);
      checkOutput("rst_entries", entries_loaded_o, 0);
      checkOutput("rst_src_addr", src_addr_o, 0);
      checkOutput("rst_lut_addr", lut_addr_o, 0);
      rst_n_20mhz = 1'b1;
      @(negedge clk_20mhz);

      // Bad counts: 0 and LUT_DEPTH+1
      $display("[TB] bad entry counts");
      applyStimulus(0, 1'b0);
      waitIdle(5, c);
      checkOutput("err0_flag", load_err_o, 1);
      checkOutput("err0_done", config_done_o, 0);
      checkOutput("err0_entries", entries_loaded_o, 0);
      applyStimulus(257, 1'b0);
      waitIdle(5, c);
      checkOutput("err257_flag", load_err_o, 1);
      checkOutput("err257_done", config_done_o, 0);
      checkOutput("err_no_wen", wrCount, 0);

      // Basic 4-entry load
      $display("[TB] 4-entry load");
      applyStimulus(4, 1'b1);
      checkOutput("t1_err_cleared", load_err_o, 0);
      checkOutput("t1_busy", busy_o, 1);
      waitIdle(40, c);
      checkOutput("t1_done_cycle", c, (VERIFY != 0) ? 18 : 10);
      checkOutput("t1_done", config_done_o, 1);
      checkOutput("t1_entries", entries_loaded_o, 4);
      checkOutput("t1_wr_count", wrCount, 4);
      checkOutput("t1_src_rd_count", srcRdCount, (VERIFY != 0) ? 8 : 4);
      checkOutput("t1_sb_drained", expQ.size(), 0);
      checkOutput("t1_verify_err", verify_err_o, 0);
      @(negedge clk_20mhz);
      checkOutput("t1_done_holds", config_done_o, 1);

      // Held off by a busy sequencer, busy rising mid-load is ignored
      $display("[TB] sequencer busy gating");
      seq_busy_i = 1'b1;
      applyStimulus(5, 1'b1);
      checkOutput("t3_done_cleared", config_done_o, 0);
      repeat (49) @(negedge clk_20mhz);
      checkOutput("t3_busy_pend", busy_o, 1);
      checkOutput("t3_no_src_rd", srcRdCount, 0);
      checkOutput("t3_no_wen", wrCount, 0);
      seq_busy_i = 1'b0;
      repeat (4) @(negedge clk_20mhz);
      seq_busy_i = 1'b1;
      waitIdle(60, c);
      seq_busy_i = 1'b0;
      checkOutput("t3_wr_count", wrCount, 5);
      checkOutput("t3_done", config_done_o, 1);
      checkOutput("t3_sb_drained", expQ.size(), 0);

      // Second start during a 16-entry load is ignored
      $display("[TB] start during load");
      @(negedge clk_20mhz);
      doneBefore = doneRises;
      applyStimulus(16, 1'b1);
      checkOutput("t4_done_dropped", config_done_o, 0);
      repeat (5) @(negedge clk_20mhz);
      applyStimulus(3, 1'b0);
      waitIdle(100, c);
      @(negedge clk_20mhz);
      checkOutput("t4_wr_count", wrCount, 16);
      checkOutput("t4_entries", entries_loaded_o, 16);
      checkOutput("t4_done_rises", doneRises - doneBefore, 1);
      checkOutput("t4_load_err", load_err_o, 0);
      checkOutput("t4_sb_drained", expQ.size(), 0);

      // Reset in the middle of a load, then a fresh 8-entry load
      $display("[TB] reset mid-load");
      applyStimulus(8, 1'b1);
      c = 0;
      while (wrCount < 3 && c < 100) begin
         @(negedge clk_20mhz);
         c++;
      end
      checkOutput("t5_reach_3_writes", c < 100, 1);
      #5 rst_n_20mhz = 1'b0;
      #1;
      checkOutput("t5_rst_busy", busy_o, 0);
      checkOutput("t5_rst_src_rd", src_rd_o, 0);
      checkOutput("t5_rst_wen", lut_wen_o, 0);
      checkOutput("t5_rst_done", config_done_o, 0);
      checkOutput("t5_rst_entries", entries_loaded_o, 0);
      checkOutput("t5_rst_lut_addr", lut_addr_o, 0);
      expQ.delete();
      @(negedge clk_20mhz);
      rst_n_20mhz = 1'b1;
      applyStimulus(8, 1'b1);
      waitIdle(60, c);
      checkOutput("t5_wr_count", wrCount, 8);
      checkOutput("t5_entries", entries_loaded_o, 8);
      checkOutput("t5_done", config_done_o, 1);
      checkOutput("t5_sb_drained", expQ.size(), 0);

`ifdef SEQ_LUT_VERIFY_EN
      // Readback verification with and without a corrupted LUT entry
      $display("[TB] readback verify");
      @(negedge clk_20mhz);
      corruptAddr2 = 1'b1;
      applyStimulus(4, 1'b1);
      waitIdle(60, c);
      checkOutput("t6_bad_cycle", c, 18);
      checkOutput("t6_bad_verify_err", verify_err_o, 1);
      checkOutput("t6_bad_done", config_done_o, 0);
      checkOutput("t6_bad_wr_count", wrCount, 4);
      @(negedge clk_20mhz);
      checkOutput("t6_bad_done_idle", config_done_o, 0);
      corruptAddr2 = 1'b0;
      applyStimulus(4, 1'b1);
      checkOutput("t6_verify_err_cleared", verify_err_o, 0);
      waitIdle(60, c);
      checkOutput("t6_good_verify_err", verify_err_o, 0);
      checkOutput("t6_good_done", config_done_o, 1);
`endif

      repeat (2) @(negedge clk_20mhz);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
